xtu_mem_target: RTL and testbench
=================================

XTU_MEM_TARGET -- requirements
Module: xtu_mem_target

Interface
REQ-001 Parameter D, default 32, data width in bits (multiple of 8).
REQ-002 Parameter DA, default 32, request address width.
REQ-003 Parameter VCN, default 2, number of virtual channels; VW = $clog2(VCN).
REQ-004 Parameter SB, default 8, sideband width carried from request to response.
REQ-005 Parameter AW, default 8, memory index width; depth 2**AW words.
REQ-006 Parameter BUF, default 4, response buffer depth (>=2).
REQ-007 clk  in  1  clock; all state changes on rising edge.
REQ-008 rstn  in  1  reset, synchronous, active-low.
REQ-009 req_vld  in  1  request valid.
REQ-010 req_gnt  out  1  request accepted when req_vld & req_gnt.
REQ-011 req_vc  in  VW  request virtual channel.
REQ-012 req_wr  in  1  1 = write, 0 = read.
REQ-013 req_adr  in  DA  byte address.
REQ-014 req_stb  in  D/8  byte write strobes.
REQ-015 req_dat  in  D  write data.
REQ-016 req_sb  in  SB  request sideband.
REQ-017 rsp_vld  out  1  response valid.
REQ-018 rsp_gnt  in  1  response consumed when rsp_vld & rsp_gnt.
REQ-019 rsp_vc  out  VW  response VC (= request VC).
REQ-020 rsp_dat  out  D  read data; 0 for write responses.
REQ-021 rsp_sb  out  SB  response sideband (= request sideband).

Function
REQ-022 Block SHALL be the target memory consuming XTU requests and returning exactly one response per accepted request, in acceptance order.
REQ-023 Word index SHALL be req_adr[AW+$clog2(D/8)-1 : $clog2(D/8)]; upper and low byte-offset bits ignored (aliasing).
REQ-024 Accepted write at edge t SHALL update only bytes with req_stb[i]=1; other bytes unchanged; req_stb=0 leaves word unchanged but still responds.
REQ-025 Reads SHALL ignore req_stb and req_dat.
REQ-026 Pipeline: accept at edge t loads stage register (pipe_vld, vc, sb, wr, read data); entry pushed to response FIFO at edge t+1; rsp_vld earliest in cycle after t+1 (2-cycle accept-to-rsp_vld latency when FIFO empty).
REQ-027 Read issued the cycle after a write to the same word SHALL return the newly written data.
REQ-028 req_gnt SHALL be combinational: rstn=1 and (fifo_count + pipe_vld) < BUF; SHALL NOT depend on rsp_gnt or req_vld.
REQ-029 Response FIFO: BUF entries of {vc, sb, dat}, wrap-around read/write pointers, count 0..BUF; rsp_vld = (count != 0); outputs driven from head entry.
REQ-030 Simultaneous push and pop SHALL keep count unchanged, including at count=BUF-1 and count=1.
REQ-031 Push to a full FIFO SHALL never occur (guaranteed by REQ-028); pop of empty never occurs since rsp_vld=0.
REQ-032 Head entry and rsp_vld SHALL stay stable while rsp_vld & !rsp_gnt.
REQ-033 Sustained throughput SHALL be one request per cycle when rsp_gnt held 1.

Reset
REQ-034 While rstn=0 at an edge: fifo_count=0, pointers=0, pipe_vld=0; thereafter rsp_vld=0 and req_gnt=0 until rstn=1.
REQ-035 rsp_vc, rsp_sb, rsp_dat SHALL read 0 after reset until first push.
REQ-036 Memory array SHALL NOT be reset; contents persist across reset; reset mid-operation discards in-flight and buffered responses without memory corruption of already-accepted writes.

Verification
REQ-037 Write adr 0x10, stb 0xF, dat 0xDEADBEEF, vc 1, sb 0x5A; then read adr 0x10 -> write rsp dat 0, vc 1, sb 0x5A; read rsp dat 0xDEADBEEF.
REQ-038 Write 0x11223344 stb 0xF, then write 0xAABBCCDD stb 0x5 same adr, read -> 0x11BB33DD.
REQ-039 rsp_gnt=0, 6 back-to-back reads -> exactly BUF=4 accepted (req_gnt drops after 4), rsp_vld held; release rsp_gnt -> 4 responses in order, then remaining 2 accepted.
REQ-040 Write adr 0x20 followed next cycle by read adr 0x20 -> read returns new data; adr 0x20 and 0x20+(4<<AW) alias.
REQ-041 Continuous requests with rsp_gnt=1 for 20 cycles -> 20 responses, one per cycle after latency 2.
REQ-042 Assert rstn=0 with 3 responses buffered -> rsp_vld=0, req_gnt=0; after release, read earlier written address returns prior data.

Source files
------------

// File: rtl/xtu_mem_target.sv
// xtu_mem_target: XTU target memory with byte-strobed writes, a one-stage
// read pipeline and an in-order response FIFO. req_gnt is combinational and
// reserves a FIFO slot for the entry held in the pipeline stage.
module xtu_mem_target #(
  parameter int unsigned D   = 32,
  parameter int unsigned DA  = 32,
  parameter int unsigned VCN = 2,
  parameter int unsigned SB  = 8,
  parameter int unsigned AW  = 8,
  parameter int unsigned BUF = 4,
  localparam int unsigned VW = (VCN > 1) ? $clog2(VCN) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_vld,
  output logic            req_gnt,
  input  logic [VW-1:0]   req_vc,
  input  logic            req_wr,
  input  logic [DA-1:0]   req_adr,
  input  logic [D/8-1:0]  req_stb,
  input  logic [D-1:0]    req_dat,
  input  logic [SB-1:0]   req_sb,
  output logic            rsp_vld,
  input  logic            rsp_gnt,
  output logic [VW-1:0]   rsp_vc,
  output logic [D-1:0]    rsp_dat,
  output logic [SB-1:0]   rsp_sb
);

  localparam int unsigned NB    = D / 8;
  localparam int unsigned BO    = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = $clog2(BUF + 1);
  localparam int unsigned PW    = $clog2(BUF);

  logic [D-1:0]    mem [DEPTH];
  logic [AW-1:0]   idx;
  logic            acc;

  logic            pipe_vld;
  logic [VW-1:0]   pipe_vc;
  logic [SB-1:0]   pipe_sb;
  logic            pipe_wr;
  logic [D-1:0]    pipe_dat;

  logic [VW-1:0]   f_vc  [BUF];
  logic [SB-1:0]   f_sb  [BUF];
  logic [D-1:0]    f_dat [BUF];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   fifo_cnt;
  logic            push;
  logic            pop;

  // Upper and byte-offset address bits are intentionally ignored (aliasing).
  logic            unused_adr;
  assign unused_adr = ^req_adr;

  assign idx = req_adr[AW+BO-1:BO];
  assign acc = req_vld & req_gnt;

  // Grant while the FIFO plus the in-flight stage entry leaves room.
  assign req_gnt = rstn && (((CW+1)'(fifo_cnt) + (CW+1)'(pipe_vld)) < (CW+1)'(BUF));

  assign push = pipe_vld;
  assign pop  = (fifo_cnt != '0) && rsp_gnt;

  assign rsp_vld = (fifo_cnt != '0);
  assign rsp_vc  = f_vc[rptr];
  assign rsp_sb  = f_sb[rptr];
  assign rsp_dat = f_dat[rptr];

  // Byte-strobed write into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (acc && req_wr) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (req_stb[i]) mem[idx][i*8 +: 8] <= req_dat[i*8 +: 8];
      end
    end
  end

  // Pipeline stage: capture request attributes and read data on accept.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_vld <= 1'b0;
      pipe_vc  <= '0;
      pipe_sb  <= '0;
      pipe_wr  <= 1'b0;
      pipe_dat <= '0;
    end else begin
      pipe_vld <= acc;
      if (acc) begin
        pipe_vc  <= req_vc;
        pipe_sb  <= req_sb;
        pipe_wr  <= req_wr;
        pipe_dat <= req_wr ? '0 : mem[idx];
      end
    end
  end

  // Response FIFO: push from the stage, pop on handshake, wrap-around pointers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < int'(BUF); i++) begin
        f_vc[i]  <= '0;
        f_sb[i]  <= '0;
        f_dat[i] <= '0;
      end
    end else begin
      if (push) begin
        f_vc[wptr]  <= pipe_vc;
        f_sb[wptr]  <= pipe_sb;
        f_dat[wptr] <= pipe_wr ? '0 : pipe_dat;
        wptr        <= (wptr == PW'(BUF - 1)) ? '0 : wptr + PW'(1);
      end
      if (pop) begin
        rptr <= (rptr == PW'(BUF - 1)) ? '0 : rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_xtu_mem_target.sv
// Scoreboard bench for xtu_mem_target: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_xtu_mem_target;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_vld;
  logic        req_gnt;
  logic [0:0]  req_vc;
  logic        req_wr;
  logic [31:0] req_adr;
  logic [3:0]  req_stb;
  logic [31:0] req_dat;
  logic [7:0]  req_sb;
  logic        rsp_vld;
  logic        rsp_gnt;
  logic [0:0]  rsp_vc;
  logic [31:0] rsp_dat;
  logic [7:0]  rsp_sb;

  typedef struct {
    logic [0:0]  vc;
    logic [7:0]  sb;
    logic [31:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   rsp_cyc_q[$];
  int   acc_cyc_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_acc  = 0;

  xtu_mem_target dut (
    .clk     (clk),
    .rstn    (rstn),
    .req_vld (req_vld),
    .req_gnt (req_gnt),
    .req_vc  (req_vc),
    .req_wr  (req_wr),
    .req_adr (req_adr),
    .req_stb (req_stb),
    .req_dat (req_dat),
    .req_sb  (req_sb),
    .rsp_vld (rsp_vld),
    .rsp_gnt (rsp_gnt),
    .rsp_vc  (rsp_vc),
    .rsp_dat (rsp_dat),
    .rsp_sb  (rsp_sb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every response handshake pops one expected entry.
  always @(negedge clk) begin
    if (rstn === 1'b1 && rsp_vld === 1'b1 && rsp_gnt === 1'b1) begin
      exp_t e;
      rsp_cyc_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_dat", 64'(rsp_dat), 64'(e.dat));
        chk("rsp_vc",  64'(rsp_vc),  64'(e.vc));
        chk("rsp_sb",  64'(rsp_sb),  64'(e.sb));
      end
    end
  end

  // Present one request and hold it until granted; returns just after the accept edge.
  task automatic send(input bit wr, input logic [31:0] adr, input logic [3:0] stb,
                      input logic [31:0] dat, input logic [0:0] vc, input logic [7:0] sbv,
                      input logic [31:0] exp_dat);
    bit ok = 1'b0;
    req_vld = 1'b1;
    req_wr  = wr;
    req_adr = adr;
    req_stb = stb;
    req_dat = dat;
    req_vc  = vc;
    req_sb  = sbv;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (req_gnt === 1'b1) begin
        exp_t e;
        e.vc  = vc;
        e.sb  = sbv;
        e.dat = exp_dat;
        sb_q.push_back(e);
        acc_cyc_q.push_back(cyc);
        n_acc++;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("req_gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    req_vld = 1'b0;
    req_wr  = 1'b0;
    req_stb = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_left", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int base;
    rstn    = 1'b0;
    rsp_gnt = 1'b1;
    req_vld = 1'b0;
    req_wr  = 1'b0;
    req_adr = '0;
    req_stb = '0;
    req_dat = '0;
    req_vc  = '0;
    req_sb  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_req_gnt", 64'(req_gnt), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("post_rst_rsp_dat", 64'(rsp_dat), 64'd0);
    chk("post_rst_rsp_vc",  64'(rsp_vc),  64'd0);
    chk("post_rst_rsp_sb",  64'(rsp_sb),  64'd0);
    chk("post_rst_req_gnt", 64'(req_gnt), 64'd1);
    @(posedge clk); #1;

    // Write then read, check 2-cycle latency on the write response
    acc_cyc_q.delete(); rsp_cyc_q.delete();
    send(1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 8'h5A, 32'h0);
    send(0, 32'h10, 4'h0, 32'h0,        1'b1, 8'h5A, 32'hDEADBEEF);
    idle(4);
    chk("latency", 64'(rsp_cyc_q[0] - acc_cyc_q[0]), 64'd2);

    // Partial strobe merge
    send(1, 32'h40, 4'hF, 32'h11223344, 1'b0, 8'h01, 32'h0);
    send(1, 32'h40, 4'h5, 32'hAABBCCDD, 1'b1, 8'h02, 32'h0);
    send(0, 32'h40, 4'hF, 32'hFFFFFFFF, 1'b0, 8'h03, 32'h11BB33DD);
    // Zero strobe leaves word unchanged but still responds
    send(1, 32'h40, 4'h0, 32'h99999999, 1'b1, 8'h04, 32'h0);
    send(0, 32'h41, 4'h0, 32'h0,        1'b1, 8'h05, 32'h11BB33DD);
    // Read-after-write next cycle, and aliasing of upper/offset bits
    send(1, 32'h20, 4'hF, 32'h0BADCAFE, 1'b0, 8'h10, 32'h0);
    send(0, 32'h20, 4'h0, 32'h0,        1'b0, 8'h11, 32'h0BADCAFE);
    send(0, 32'h20 + (32'd4 << 8) + 32'd3, 4'h0, 32'h0, 1'b1, 8'h12, 32'h0BADCAFE);
    idle(1);
    drain();

    // Backpressure: 6 reads with rsp_gnt=0, only 4 accepted
    for (int i = 0; i < 6; i++) send(1, 32'h300 + 32'(4*i), 4'hF, 32'hA0000000 + 32'(i), 1'b0, 8'h00, 32'h0);
    idle(1);
    drain();
    rsp_gnt = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(0, 32'h300 + 32'(4*i), 4'h0, 32'h0, 1'(i), 8'h20 + 8'(i), 32'hA0000000 + 32'(i));
        idle(1);
      end
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepted", 64'(n_acc - base), 64'd4);
        chk("bp_req_gnt",  64'(req_gnt), 64'd0);
        chk("bp_rsp_vld",  64'(rsp_vld), 64'd1);
        chk("bp_head_dat", 64'(rsp_dat), 64'hA0000000);
        @(posedge clk); #1;
        rsp_gnt = 1'b1;
      end
    join
    drain();

    // Sustained throughput: 20 back-to-back requests
    acc_cyc_q.delete(); rsp_cyc_q.delete();
    for (int i = 0; i < 10; i++) send(1, 32'h200 + 32'(4*i), 4'hF, 32'h50000000 + 32'(i), 1'(i), 8'h40 + 8'(i), 32'h0);
    for (int i = 0; i < 10; i++) send(0, 32'h200 + 32'(4*i), 4'h0, 32'h0, 1'(i), 8'h60 + 8'(i), 32'h50000000 + 32'(i));
    idle(1);
    drain();
    chk("tp_rsp_count", 64'(rsp_cyc_q.size()), 64'd20);
    if (rsp_cyc_q.size() == 20 && acc_cyc_q.size() == 20) begin
      chk("tp_acc_span",  64'(acc_cyc_q[19] - acc_cyc_q[0]), 64'd19);
      chk("tp_rsp_span",  64'(rsp_cyc_q[19] - rsp_cyc_q[0]), 64'd19);
      chk("tp_latency",   64'(rsp_cyc_q[0] - acc_cyc_q[0]), 64'd2);
    end

    // Reset with 3 responses buffered; memory keeps accepted writes
    rsp_gnt = 1'b0;
    send(1, 32'h30, 4'hF, 32'hCAFEF00D, 1'b1, 8'h77, 32'h0);
    send(0, 32'h10, 4'h0, 32'h0, 1'b0, 8'h78, 32'hDEADBEEF);
    send(0, 32'h10, 4'h0, 32'h0, 1'b1, 8'h79, 32'hDEADBEEF);
    idle(3);
    chk("pre_rst_rsp_vld", 64'(rsp_vld), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_gnt", 64'(req_gnt), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("mid_rst_rsp_dat", 64'(rsp_dat), 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    rsp_gnt = 1'b1;
    @(negedge clk);
    chk("rel_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rel_rsp_sb",  64'(rsp_sb),  64'd0);
    chk("rel_req_gnt", 64'(req_gnt), 64'd1);
    @(posedge clk); #1;
    send(0, 32'h10, 4'h0, 32'h0, 1'b0, 8'h81, 32'hDEADBEEF);
    send(0, 32'h30, 4'h0, 32'h0, 1'b1, 8'h82, 32'hCAFEF00D);
    send(0, 32'h40, 4'h0, 32'h0, 1'b0, 8'h83, 32'h11BB33DD);
    idle(1);
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
